ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk rising-edge; rst asserted (1) clears all state immediately, independent of clk.
REQ-002 SHALL have ports, in this order:
- clk  in  1  pipeline clock
- rst  in  1  async reset, active-high
- stall  in  6  pipeline stall vector; bit3 = EX stalled, bit4 = MEM stalled
- flush  in  1  discard the EX→MEM slot
- ex_waddr  in  5  destination register address
- ex_reg_we  in  1  register write enable
- ex_alu_res  in  32  ALU result
- ex_hi_we, ex_lo_we  in  1 each  HI/LO write enables
- ex_hi, ex_lo  in  32 each  HI/LO write data
- ex_aluop  in  8  operation code
- ex_mem_addr  in  32  load/store effective address
- ex_reg2_data  in  32  store data
- ex_inst  in  32  instruction word, debug only
- hilo_temp_i  in  64  multiply-accumulate partial product from EX
- cnt_i  in  2  multiply-accumulate cycle count from EX
- mem_*  out  (matching widths)  registered copies of every ex_* input
- mem_valid  out  1  slot holds a real instruction
- hilo_temp_o  out  64  partial product returned to EX
- cnt_o  out  2  cycle count returned to EX
- bubble_cnt  out  16  count of bubbles inserted, debug

Function
REQ-003 SHALL update all outputs only on the rising edge of clk while rst=0; no combinational path from any input to any output.
REQ-004 SHALL evaluate the following cases each edge, highest priority first.
REQ-005 flush=1: SHALL load a bubble (REQ-008), set hilo_temp_o=0 and cnt_o=0, and leave bubble_cnt unchanged.
REQ-006 stall[3]=1 and stall[4]=0 (EX held, MEM advances):
- SHALL load a bubble.
- SHALL set hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i, preserving multiply-accumulate progress.
- SHALL increment bubble_cnt.
REQ-007 stall[4]=1 (MEM held, regardless of stall[3]): SHALL hold every output at its current value.
REQ-008 A bubble SHALL mean:
- mem_waddr=0, mem_reg_we=0, mem_hi_we=0, mem_lo_we=0;
- mem_alu_res, mem_hi, mem_lo, mem_mem_addr, mem_reg2_data, mem_inst = 0;
- mem_aluop = 0 (NOP);
- mem_valid=0.
REQ-009 stall[3]=0 and stall[4]=0 (normal advance):
- SHALL copy every ex_* input to the matching mem_* output;
- SHALL set mem_valid=1;
- SHALL set hilo_temp_o=0 and cnt_o=0.
REQ-010 Latency SHALL be exactly one cycle from EX inputs to mem_* outputs in the advance case.
REQ-011 bubble_cnt SHALL saturate at 16'hFFFF; it does not wrap.
REQ-012 The stall vector SHALL be treated as monotonic by the hazard unit; the pattern stall[3]=0 with stall[4]=1 SHALL still obey REQ-007 (hold).

Reset
REQ-013 While rst=1, SHALL force:
- every mem_* output to 0;
- mem_valid=0;
- hilo_temp_o=0, cnt_o=0;
- bubble_cnt=0.
REQ-014 Reset asserted mid-stall SHALL abandon any multiply-accumulate progress; after release, the first edge SHALL follow REQ-004 through REQ-009 with no residual state.

Verification
REQ-015 Advance: stall=0, ex_waddr=5'd3, ex_reg_we=1, ex_alu_res=32'h1234_5678 -> next edge mem_waddr=3, mem_reg_we=1, mem_alu_res=32'h1234_5678, mem_valid=1.
REQ-016 EX stall: stall=6'b001111, hilo_temp_i=64'hA, cnt_i=2'd1 -> next edge:
- mem_reg_we=0, mem_valid=0;
- hilo_temp_o=64'hA, cnt_o=1;
- bubble_cnt incremented by 1.
REQ-017 MEM stall: load an advance value, then apply stall=6'b011111 for 3 edges with changing ex_* inputs -> all outputs unchanged for those 3 edges.
REQ-018 Flush priority: flush=1 together with stall=6'b001111 -> bubble loaded, hilo_temp_o=0, cnt_o=0, bubble_cnt unchanged.
REQ-019 Async reset: raise rst between clock edges while mem_valid=1 -> all outputs 0 before the next edge; release rst, apply stall=0 -> normal advance on the first edge.
REQ-020 Saturation: preload bubble_cnt to 16'hFFFE by applying the EX-stall pattern, then apply 2 more EX-stall edges -> bubble_cnt = 16'hFFFF and remains there.

Source files
------------

// File: rtl/ex_mem.sv
// EX->MEM pipeline register: carries the EX result into MEM, inserts bubbles on
// flush or EX-only stall, and loops multiply-accumulate state back to EX.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_reg_we,
    input  logic [31:0] ex_alu_res,
    input  logic        ex_hi_we,
    input  logic        ex_lo_we,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2_data,
    input  logic [31:0] ex_inst,
    input  logic [63:0] hilo_temp_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_waddr,
    output logic        mem_reg_we,
    output logic [31:0] mem_alu_res,
    output logic        mem_hi_we,
    output logic        mem_lo_we,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [7:0]  mem_aluop,
    output logic [31:0] mem_mem_addr,
    output logic [31:0] mem_reg2_data,
    output logic [31:0] mem_inst,
    output logic        mem_valid,
    output logic [63:0] hilo_temp_o,
    output logic [1:0]  cnt_o,
    output logic [15:0] bubble_cnt
);
    typedef struct packed {
        logic [4:0]  waddr;
        logic        reg_we;
        logic [31:0] alu_res;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2_data;
        logic [31:0] inst;
    } slot_t;

    slot_t ex_slot, mem_slot;

    // Only the EX and MEM stall bits matter at this boundary.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    assign ex_slot = {ex_waddr, ex_reg_we, ex_alu_res, ex_hi_we, ex_lo_we, ex_hi,
                      ex_lo, ex_aluop, ex_mem_addr, ex_reg2_data, ex_inst};

    assign {mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we, mem_hi,
            mem_lo, mem_aluop, mem_mem_addr, mem_reg2_data, mem_inst} = mem_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_slot    <= '0;
            mem_valid   <= 1'b0;
            hilo_temp_o <= '0;
            cnt_o       <= '0;
            bubble_cnt  <= '0;
        end else if (flush) begin
            mem_slot    <= '0;
            mem_valid   <= 1'b0;
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end else if (stall[3] && !stall[4]) begin
            // EX holds while MEM drains: keep MAC progress alive across the bubble.
            mem_slot    <= '0;
            mem_valid   <= 1'b0;
            hilo_temp_o <= hilo_temp_i;
            cnt_o       <= cnt_i;
            if (bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end else if (!stall[4]) begin
            mem_slot    <= ex_slot;
            mem_valid   <= 1'b1;
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end
    end
endmodule

// File: tb/tb_ex_mem.sv
// Randomized bench for ex_mem against a record-level reference model.
module tb_ex_mem;
    typedef struct packed {
        logic [4:0]  waddr;
        logic        reg_we;
        logic [31:0] alu_res;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2_data;
        logic [31:0] inst;
    } in_t;

    typedef struct packed {
        in_t         slot;
        logic        valid;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [15:0] bub;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] stall = '0;
    logic flush = 1'b0;
    in_t ex = '0;
    logic [63:0] hilo_temp_i = '0;
    logic [1:0] cnt_i = '0;

    logic [4:0]  ex_waddr, mem_waddr;
    logic        ex_reg_we, mem_reg_we, ex_hi_we, mem_hi_we, ex_lo_we, mem_lo_we;
    logic [31:0] ex_alu_res, mem_alu_res, ex_hi, mem_hi, ex_lo, mem_lo;
    logic [7:0]  ex_aluop, mem_aluop;
    logic [31:0] ex_mem_addr, mem_mem_addr, ex_reg2_data, mem_reg2_data, ex_inst, mem_inst;
    logic        mem_valid;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    out_t dut_out, exp_out;
    int n_chk = 0;
    int n_pass = 0;

    assign {ex_waddr, ex_reg_we, ex_alu_res, ex_hi_we, ex_lo_we, ex_hi, ex_lo,
            ex_aluop, ex_mem_addr, ex_reg2_data, ex_inst} = ex;
    assign dut_out = {mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we, mem_hi,
                      mem_lo, mem_aluop, mem_mem_addr, mem_reg2_data, mem_inst,
                      mem_valid, hilo_temp_o, cnt_o, bubble_cnt};

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we), .ex_alu_res(ex_alu_res),
        .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2_data(ex_reg2_data),
        .ex_inst(ex_inst), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we), .mem_alu_res(mem_alu_res),
        .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2_data(mem_reg2_data),
        .mem_inst(mem_inst), .mem_valid(mem_valid), .hilo_temp_o(hilo_temp_o),
        .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference: what the MEM slot should hold after one edge, by the stated rules.
    function automatic out_t model(out_t cur, logic fl, logic [5:0] st, in_t e,
                                   logic [63:0] hi_i, logic [1:0] c_i);
        out_t n = cur;
        int b;
        if (fl) begin
            n.slot = '0; n.valid = 1'b0; n.hilo = '0; n.cnt = '0;
        end else if (st[4]) begin
            n = cur;
        end else if (st[3]) begin
            b = int'(cur.bub) + 1;
            n.slot = '0; n.valid = 1'b0; n.hilo = hi_i; n.cnt = c_i;
            n.bub = (b > 65535) ? 16'hFFFF : 16'(b);
        end else begin
            n.slot = e; n.valid = 1'b1; n.hilo = '0; n.cnt = '0;
        end
        return n;
    endfunction

    task automatic rand_inputs();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        ex = r[207:0];
        hilo_temp_i = {$urandom, $urandom};
        cnt_i = 2'($urandom_range(0, 3));
    endtask

    // One clock edge; leaves time at posedge+1 with exp_out updated.
    task automatic tick();
        out_t nxt;
        nxt = model(exp_out, flush, stall, ex, hilo_temp_i, cnt_i);
        @(posedge clk);
        #1;
        exp_out = nxt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_out = '0;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (dut_out !== out_t'(0)) $display("FAIL reset_state: got %h want 0", dut_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_out = '0;
    endtask

    task automatic test_advance();
        stall = '0; flush = 1'b0;
        rand_inputs();
        ex.waddr = 5'd3; ex.reg_we = 1'b1; ex.alu_res = 32'h1234_5678;
        tick();
        n_chk++;
        if (mem_waddr !== 5'd3 || mem_reg_we !== 1'b1 || mem_alu_res !== 32'h1234_5678 ||
            mem_valid !== 1'b1)
            $display("FAIL advance_directed: got waddr=%0d we=%b res=%h v=%b want 3 1 12345678 1",
                     mem_waddr, mem_reg_we, mem_alu_res, mem_valid);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            tick();
            n_chk++;
            if (dut_out !== exp_out) $display("FAIL advance_rand: got %h want %h", dut_out, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_ex_stall();
        logic [15:0] b0;
        b0 = bubble_cnt;
        rand_inputs();
        stall = 6'b001111; hilo_temp_i = 64'hA; cnt_i = 2'd1;
        tick();
        n_chk++;
        if (mem_reg_we !== 1'b0 || mem_valid !== 1'b0 || hilo_temp_o !== 64'hA ||
            cnt_o !== 2'd1 || bubble_cnt !== b0 + 16'd1)
            $display("FAIL ex_stall_directed: got we=%b v=%b hilo=%h cnt=%0d bub=%0d want 0 0 a 1 %0d",
                     mem_reg_we, mem_valid, hilo_temp_o, cnt_o, bubble_cnt, b0 + 16'd1);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            tick();
            n_chk++;
            if (dut_out !== exp_out) $display("FAIL ex_stall_rand: got %h want %h", dut_out, exp_out);
            else n_pass++;
        end
        stall = '0;
    endtask

    task automatic test_mem_stall();
        out_t held;
        stall = '0; flush = 1'b0;
        rand_inputs();
        tick();
        held = exp_out;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = (i == 2) ? 6'b010000 : 6'b011111;
            tick();
            n_chk++;
            if (dut_out !== held) $display("FAIL mem_stall_hold: got %h want %h", dut_out, held);
            else n_pass++;
        end
        stall = '0;
    endtask

    task automatic test_flush();
        logic [15:0] b0;
        stall = '0; rand_inputs(); tick();
        b0 = bubble_cnt;
        rand_inputs();
        flush = 1'b1; stall = 6'b001111;
        tick();
        n_chk++;
        if (mem_valid !== 1'b0 || mem_reg_we !== 1'b0 || hilo_temp_o !== 64'd0 ||
            cnt_o !== 2'd0 || bubble_cnt !== b0 || dut_out.slot !== in_t'(0))
            $display("FAIL flush_priority: got %h want bubble with bub=%0d", dut_out, b0);
        else n_pass++;
        stall = '0; flush = 1'b0; rand_inputs(); tick();
        flush = 1'b1; stall = 6'b011111;
        tick();
        n_chk++;
        if (dut_out !== exp_out) $display("FAIL flush_over_mem_stall: got %h want %h", dut_out, exp_out);
        else n_pass++;
        flush = 1'b0; stall = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            flush = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: stall = 6'b001111;
                1: stall = 6'b011111;
                default: stall = 6'b000000;
            endcase
            tick();
            n_chk++;
            if (dut_out !== exp_out) $display("FAIL random_mix: got %h want %h", dut_out, exp_out);
            else n_pass++;
        end
        flush = 1'b0; stall = '0;
    endtask

    task automatic test_async_reset();
        stall = '0; rand_inputs(); tick();
        stall = 6'b001111; hilo_temp_i = 64'h1234; cnt_i = 2'd2; tick();
        stall = '0; rand_inputs(); tick();
        rst = 1'b1;
        #1;
        n_chk++;
        if (dut_out !== out_t'(0)) $display("FAIL async_reset: got %h want 0", dut_out);
        else n_pass++;
        #1;
        rst = 1'b0;
        exp_out = '0;
        stall = 6'b001111; hilo_temp_i = 64'h55; cnt_i = 2'd3; tick();
        rst = 1'b1;
        #1;
        n_chk++;
        if (dut_out !== out_t'(0)) $display("FAIL reset_mid_stall: got %h want 0", dut_out);
        else n_pass++;
        #1;
        rst = 1'b0;
        exp_out = '0;
        stall = '0; rand_inputs(); tick();
        n_chk++;
        if (dut_out !== exp_out || mem_valid !== 1'b1 || hilo_temp_o !== 64'd0)
            $display("FAIL advance_after_reset: got %h want %h", dut_out, exp_out);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        stall = 6'b001111;
        for (int i = 0; i < 65534; i++) begin
            rand_inputs();
            tick();
        end
        n_chk++;
        if (bubble_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h want fffe", bubble_cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick();
            n_chk++;
            if (bubble_cnt !== 16'hFFFF || dut_out !== exp_out)
                $display("FAIL sat_hold: got %h want bub ffff / %h", dut_out, exp_out);
            else n_pass++;
        end
        stall = '0;
    endtask

    initial begin
        exp_out = '0;
        test_reset();
        test_advance();
        test_ex_stall();
        test_mem_stall();
        test_flush();
        test_random();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
